// File: rtl/pmod_meter_pkg.sv
// Shared constants and FSM state type for the PMOD edge meter.
package pmod_meter_pkg;

  localparam int NUM_CH          = 4;
  localparam int DEF_GATE_CYCLES = 48_000_000;
  localparam int DEF_CNT_W       = 24;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/pmod_edge_meter_edge_sync.sv
// One-bit 2-FF synchronizer followed by a rising-edge detector.
// The pulse is combinational from the synchronized stage and its history flop.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/pmod_edge_meter.sv
// Counts rising edges on four PMOD inputs over back-to-back gate windows and
// presents the latched per-channel counts through a valid/ack handshake.
module pmod_edge_meter
  import pmod_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        pmod_in,
  input  logic                     enable,
  output logic [NUM_CH*CNT_W-1:0]  result_counts,
  output logic [NUM_CH-1:0]        result_sat,
  output logic                     result_valid,
  input  logic                     result_ack,
  output logic                     overrun
);

  localparam int               TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  meter_state_t                 state;
  logic [TMR_W-1:0]             timer;
  logic [NUM_CH-1:0][CNT_W-1:0] acc;
  logic [NUM_CH-1:0][CNT_W-1:0] acc_inc;
  logic [NUM_CH-1:0]            sat;
  logic [NUM_CH-1:0]            sat_inc;
  logic [NUM_CH-1:0]            edge_pulse;
  logic                         terminal;
  logic                         accept;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    edge_sync u_edge_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (pmod_in[g]),
      .pulse (edge_pulse[g])
    );
  end

  // An edge that would overflow the counter is dropped and recorded in sat.
  always_comb begin
    acc_inc = acc;
    sat_inc = sat;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (edge_pulse[ch]) begin
        if (acc[ch] == CNT_MAX) begin
          sat_inc[ch] = 1'b1;
        end else begin
          acc_inc[ch] = acc[ch] + 1'b1;
        end
      end
    end
  end

  // Dropping enable wins over a terminal cycle: the window is discarded.
  assign terminal = (state == MEASURE) && enable && (timer == TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      acc   <= '0;
      sat   <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          acc   <= '0;
          sat   <= '0;
          if (enable) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (!enable) begin
            state <= IDLE;
            timer <= '0;
            acc   <= '0;
            sat   <= '0;
          end else if (terminal) begin
            timer <= '0;
            acc   <= '0;
            sat   <= '0;
          end else begin
            timer <= timer + 1'b1;
            acc   <= acc_inc;
            sat   <= sat_inc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake: a result transfers on any cycle with result_valid & result_ack;
  // result_valid then drops next cycle unless a new window closes on the same
  // cycle. result_ack with result_valid low has no effect.
  assign accept = result_valid & result_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_counts <= '0;
      result_sat    <= '0;
      result_valid  <= 1'b0;
      overrun       <= 1'b0;
    end else if (terminal) begin
      result_counts <= acc_inc;
      result_sat    <= sat_inc;
      result_valid  <= 1'b1;
      if (accept) begin
        overrun <= 1'b0;
      end else if (result_valid) begin
        overrun <= 1'b1;
      end
    end else if (accept) begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmod_edge_meter.sv
// Bench for pmod_edge_meter: two instances (8-bit and 5-bit counters) share
// stimulus; a window-level model and a vector table supply expected values.
module tb_pmod_edge_meter;

  localparam int GATE = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  pmod_in = 4'h0;
  logic        enable = 1'b0;
  logic        result_ack = 1'b0;

  logic [31:0] counts8;
  logic [3:0]  sat8;
  logic        valid8;
  logic        over8;
  logic [19:0] counts5;
  logic [3:0]  sat5;
  logic        valid5;
  logic        over5;

  always #5 clk = ~clk;

  pmod_edge_meter #(.GATE_CYCLES(GATE), .CNT_W(8)) u_dut8 (
    .clk           (clk),
    .rst_n         (rst_n),
    .pmod_in       (pmod_in),
    .enable        (enable),
    .result_counts (counts8),
    .result_sat    (sat8),
    .result_valid  (valid8),
    .result_ack    (result_ack),
    .overrun       (over8)
  );

  pmod_edge_meter #(.GATE_CYCLES(GATE), .CNT_W(5)) u_dut5 (
    .clk           (clk),
    .rst_n         (rst_n),
    .pmod_in       (pmod_in),
    .enable        (enable),
    .result_counts (counts5),
    .result_sat    (sat5),
    .result_valid  (valid5),
    .result_ack    (result_ack),
    .overrun       (over5)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks pin samples; a rise between two consecutive samples is counted two
  // clocks later (synchronizer delay). Windows are GATE enabled cycles long.
  logic [3:0]  pin_q[$];
  int          m_true[4];
  int          m_elapsed = 0;
  bit          m_active = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_over = 1'b0;
  bit          m_term;
  bit          m_accept;
  logic [3:0]  m_rises;
  logic [31:0] m_cnt8 = '0;
  logic [19:0] m_cnt5 = '0;
  logic [3:0]  m_sat8 = '0;
  logic [3:0]  m_sat5 = '0;

  function automatic int clamp(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pin_q = '{4'h0, 4'h0, 4'h0};
        for (int ch = 0; ch < 4; ch++) m_true[ch] = 0;
        m_elapsed = 0;
        m_active = 1'b0;
        m_valid = 1'b0;
        m_over = 1'b0;
        m_cnt8 = '0;
        m_cnt5 = '0;
        m_sat8 = '0;
        m_sat5 = '0;
      end else begin
        m_rises = pin_q[1] & ~pin_q[0];
        m_accept = m_valid && result_ack;
        m_term = 1'b0;
        if (m_active && !enable) begin
          m_active = 1'b0;
        end else if (m_active) begin
          for (int ch = 0; ch < 4; ch++) m_true[ch] += int'(m_rises[ch]);
          m_elapsed++;
          if (m_elapsed == GATE) m_term = 1'b1;
        end else if (enable) begin
          m_active = 1'b1;
          m_elapsed = 0;
          for (int ch = 0; ch < 4; ch++) m_true[ch] = 0;
        end
        if (m_term) begin
          for (int ch = 0; ch < 4; ch++) begin
            m_cnt8[ch*8 +: 8] = 8'(clamp(m_true[ch], 8));
            m_cnt5[ch*5 +: 5] = 5'(clamp(m_true[ch], 5));
            m_sat8[ch] = (m_true[ch] > 255);
            m_sat5[ch] = (m_true[ch] > 31);
            m_true[ch] = 0;
          end
          m_over = m_valid && !result_ack;
          m_valid = 1'b1;
          m_elapsed = 0;
        end else if (m_accept) begin
          m_valid = 1'b0;
          m_over = 1'b0;
        end
        void'(pin_q.pop_front());
        pin_q.push_back(pmod_in);
      end
    end
  end

  bit chk_on = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("model_dut8", {counts8, sat8, valid8, over8}, {m_cnt8, m_sat8, m_valid, m_over});
        check("model_dut5", {counts5, sat5, valid5, over5}, {m_cnt5, m_sat5, m_valid, m_over});
      end
    end
  end

  // ---------------- driver tasks ----------------
  int period[4] = '{0, 0, 0, 0};
  int wcyc = 0;
  bit wave_on = 1'b0;
  bit rand_on = 1'b0;

  task automatic tick();
    @(negedge clk);
    if (wave_on) begin
      for (int ch = 0; ch < 4; ch++)
        pmod_in[ch] = (period[ch] != 0) && ((wcyc % period[ch]) >= period[ch] / 2);
      wcyc++;
    end else if (rand_on) begin
      pmod_in = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic wait_valid(input int max_ticks, output int n);
    n = 0;
    while (!valid8 && n < max_ticks) begin
      tick();
      n++;
    end
    check("wait_valid", valid8, 1);
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          per[4];
    logic [31:0] exp8;
    logic [3:0]  esat8;
    logic [19:0] exp5;
    logic [3:0]  esat5;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    vecs[0].per = '{10, 20, 0, 4};
    vecs[0].exp8 = {8'd25, 8'd0, 8'd5, 8'd10};
    vecs[0].esat8 = 4'b0000;
    vecs[0].exp5 = {5'd25, 5'd0, 5'd5, 5'd10};
    vecs[0].esat5 = 4'b0000;
    vecs[1].per = '{2, 0, 0, 0};
    vecs[1].exp8 = {8'd0, 8'd0, 8'd0, 8'd50};
    vecs[1].esat8 = 4'b0000;
    vecs[1].exp5 = {5'd0, 5'd0, 5'd0, 5'd31};
    vecs[1].esat5 = 4'b0001;
    vecs[2].per = '{0, 0, 0, 0};
    vecs[2].exp8 = '0;
    vecs[2].esat8 = 4'b0000;
    vecs[2].exp5 = '0;
    vecs[2].esat5 = 4'b0000;
    vecs[3].per = '{4, 4, 2, 20};
    vecs[3].exp8 = {8'd5, 8'd50, 8'd25, 8'd25};
    vecs[3].esat8 = 4'b0000;
    vecs[3].exp5 = {5'd5, 5'd31, 5'd25, 5'd25};
    vecs[3].esat5 = 4'b0100;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs8", {counts8, sat8, valid8, over8}, 64'h0);
    check("reset_outputs5", {counts5, sat5, valid5, over5}, 64'h0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (3) tick();

    // Frequency table, each entry checked on a window fully inside the pattern
    enable = 1'b1;
    wave_on = 1'b1;
    foreach (vecs[i]) begin
      period = vecs[i].per;
      wait_valid(250, n);
      ack_result();
      wait_valid(150, n);
      check($sformatf("vec%0d_counts8", i), counts8, vecs[i].exp8);
      check($sformatf("vec%0d_sat8", i), sat8, vecs[i].esat8);
      check($sformatf("vec%0d_counts5", i), counts5, vecs[i].exp5);
      check($sformatf("vec%0d_sat5", i), sat5, vecs[i].esat5);
      if (i != 3) ack_result();
    end

    // Asynchronous reset mid-window with a result pending
    period = '{10, 0, 0, 0};
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset8", {counts8, sat8, valid8, over8}, 64'h0);
    check("async_reset5", {counts5, sat5, valid5, over5}, 64'h0);
    wcyc = 0;
    tick();
    rst_n = 1'b1;
    wait_valid(120, n);
    check("reset_first_latency", n, 101);
    check("reset_first_a1", counts8, 32'h0000_000a);
    ack_result();

    // Single A2 edge pulse landing on the terminal cycle
    wave_on = 1'b0;
    enable = 1'b0;
    pmod_in = 4'h0;
    repeat (4) tick();
    tick();
    enable = 1'b1;
    repeat (98) tick();
    pmod_in = 4'b0010;
    tick();
    pmod_in = 4'h0;
    wait_valid(10, n);
    check("terminal_edge_in_closing", counts8, 32'h0000_0100);
    ack_result();
    wait_valid(120, n);
    check("terminal_edge_next_window", counts8, 32'h0);
    ack_result();

    // Enable drop mid-window discards the partial window
    period = '{10, 0, 0, 0};
    wave_on = 1'b1;
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    repeat (60) tick();
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    wait_valid(300, n);
    check("reenable_latency", n, 101);
    check("reenable_counts", counts8, 32'h0000_000a);
    ack_result();

    // Handshake: two unacked windows, then ack on the third terminal cycle
    period = '{10, 0, 0, 4};
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    wait_valid(120, n);
    check("hs_first_latency", n, 101);
    check("hs_first_overrun", over8, 0);
    repeat (100) tick();
    check("hs_second_valid", valid8, 1);
    check("hs_second_overrun", over8, 1);
    repeat (99) tick();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("hs_third_valid", valid8, 1);
    check("hs_third_overrun", over8, 0);
    check("hs_third_counts", counts8, 32'h1900_000a);
    ack_result();
    check("hs_after_ack_valid", valid8, 0);

    // Randomized pins, acks and enable drops against the model
    wave_on = 1'b0;
    rand_on = 1'b1;
    repeat (3000) begin
      tick();
      result_ack = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) enable = ~enable;
    end
    result_ack = 1'b0;
    tick();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
